// File: rtl/seg_display_pkg.sv
// Shared types and helpers for the ASCII scroll buffer and its tick generator.
package seg_display_pkg;

    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic {
        IDLE,
        RUN
    } scroll_state_t;

    // Wide enough for any stream index the scroller can form (offset + digit < 2P).
    typedef logic [15:0] idx_t;

    // Single-step modulo: callers guarantee a < 2p.
    function automatic idx_t wrap_idx(input idx_t a, input idx_t p);
        return (a >= p) ? idx_t'(a - p) : a;
    endfunction

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate divider: counts TICK_DIV clocks (frozen by hold) and emits a 1-cycle step.
module scroll_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    input  logic hold,
    output logic step
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_reg;

    assign step = en && !hold && !clear && (count_reg == CW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear || !en) begin
            count_reg <= '0;
        end else if (!hold) begin
            count_reg <= step ? '0 : count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/ascii_scroll_buffer.sv
// Writable ASCII message buffer with a sliding NUM_DIGITS window feeding the
// per-digit ASCII-to-7-segment decoders; a blank gap of NUM_DIGITS follows the message.
module ascii_scroll_buffer
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int MSG_DEPTH  = 32,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          WrEn,
    input  logic [$clog2(MSG_DEPTH)-1:0]  WrAddr,
    input  logic [7:0]                    WrData,
    input  logic [$clog2(MSG_DEPTH):0]    MsgLen,
    input  logic                          Start,
    input  logic                          Stop,
    input  logic                          Hold,
    output logic [8*NUM_DIGITS-1:0]       AsciiOut,
    output logic                          Running,
    output logic                          Wrapped
);

    localparam int AW = $clog2(MSG_DEPTH);
    localparam int OW = $clog2(MSG_DEPTH + NUM_DIGITS);

    logic [7:0]              buf_reg [MSG_DEPTH];
    scroll_state_t           state_reg, state_next;
    logic [AW:0]             len_reg, len_next;
    logic [OW-1:0]           offset_reg, offset_next;
    logic                    wrapped_reg, wrapped_next;
    logic                    running_reg;
    logic [8*NUM_DIGITS-1:0] ascii_reg, ascii_next;
    logic [7:0]              digit_char [NUM_DIGITS];
    logic [AW:0]             len_clamped;
    idx_t                    period;
    logic                    step;

    assign len_clamped = (MsgLen > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : MsgLen;
    assign period      = idx_t'(len_reg) + idx_t'(NUM_DIGITS);

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (Clk),
        .rst   (Reset),
        .en    (state_reg == RUN),
        .clear (Start || Stop),
        .hold  (Hold),
        .step  (step)
    );

    // Buffer entries carry an async reset to blank, so they stay as flops.
    genvar gi;
    generate
        for (gi = 0; gi < MSG_DEPTH; gi++) begin : g_buf
            always_ff @(posedge Clk or posedge Reset) begin
                if (Reset) begin
                    buf_reg[gi] <= ASCII_BLANK;
                end else if (WrEn && (WrAddr == AW'(gi))) begin
                    buf_reg[gi] <= WrData;
                end
            end
        end

        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            idx_t pos;
            assign pos = wrap_idx(idx_t'(offset_reg) + idx_t'(gi), period);
            assign digit_char[gi] = (pos < idx_t'(len_reg)) ? buf_reg[pos[AW-1:0]] : ASCII_BLANK;
        end
    endgenerate

    // Stop blanks the display on the same edge that leaves RUN.
    always_comb begin
        ascii_next = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            ascii_next[8*(NUM_DIGITS-i)-1 -: 8] =
                (state_reg == RUN && !Stop) ? digit_char[i] : ASCII_BLANK;
        end
    end

    always_comb begin
        state_next   = state_reg;
        len_next     = len_reg;
        offset_next  = offset_reg;
        wrapped_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Start && !Stop && (MsgLen != '0)) begin
                    state_next  = RUN;
                    len_next    = len_clamped;
                    offset_next = '0;
                end
            end
            RUN: begin
                if (Stop) begin
                    state_next  = IDLE;
                    offset_next = '0;
                end else if (Start) begin
                    len_next    = len_clamped;
                    offset_next = '0;
                end else if (step) begin
                    if (idx_t'(offset_reg) == period - idx_t'(1)) begin
                        offset_next  = '0;
                        wrapped_next = 1'b1;
                    end else begin
                        offset_next = offset_reg + OW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            offset_reg  <= '0;
            wrapped_reg <= 1'b0;
            running_reg <= 1'b0;
            ascii_reg   <= {NUM_DIGITS{ASCII_BLANK}};
        end else begin
            state_reg   <= state_next;
            len_reg     <= len_next;
            offset_reg  <= offset_next;
            wrapped_reg <= wrapped_next;
            running_reg <= (state_next == RUN);
            ascii_reg   <= ascii_next;
        end
    end

    assign AsciiOut = ascii_reg;
    assign Running  = running_reg;
    assign Wrapped  = wrapped_reg;

endmodule
